// File: rtl/gray_bcd_display_ctrl_pkg.sv
// Shared state type, seven-segment patterns and helper functions for the
// Gray-to-BCD display controller.
package gray_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_e;

    // Widest Gray word gray2bin accepts; callers zero-extend narrower words.
    localparam int GRAY_MAX_W = 32;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic int bcdWidth(input int numDigits);
        return 4 * numDigits;
    endfunction

    function automatic int shiftCntWidth(input int dataW);
        return $clog2(dataW + 1);
    endfunction

    // Zero bits above the real input width leave the low result bits unchanged.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin = '0;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_bcd_display_ctrl_seg7_encoder.sv
// Combinational BCD nibble to active-low {g,f,e,d,c,b,a} segment pattern;
// codes 10-15 and an asserted blank input both produce an unlit digit.
module seg7_encoder
    import gray_bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_n_o
);

    always_comb begin
        seg_n_o = SEG_BLANK;
        if (!blank_i) begin
            case (digit_i)
                4'd0:    seg_n_o = SEG_0;
                4'd1:    seg_n_o = SEG_1;
                4'd2:    seg_n_o = SEG_2;
                4'd3:    seg_n_o = SEG_3;
                4'd4:    seg_n_o = SEG_4;
                4'd5:    seg_n_o = SEG_5;
                4'd6:    seg_n_o = SEG_6;
                4'd7:    seg_n_o = SEG_7;
                4'd8:    seg_n_o = SEG_8;
                4'd9:    seg_n_o = SEG_9;
                default: seg_n_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/gray_bcd_display_ctrl.sv
// Samples a Gray-coded input on a slow tick, converts it to binary and BCD, and
// scans it onto multiplexed seven-segment digits. LEAD_ZERO_BLANK_EN blanks leading zeros.
module gray_bcd_display_ctrl
    import gray_bcd_pkg::*;
#(
    parameter int DATA_W     = 4,
    parameter int NUM_DIGITS = 2,
    parameter int SAMPLE_DIV = 25000000,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     data_in,
    output logic [DATA_W-1:0]     bin_out,
    output logic [6:0]            seg_n,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic                  busy
);

    localparam int BCD_W    = bcdWidth(NUM_DIGITS);
    localparam int CNT_W    = shiftCntWidth(DATA_W);
    localparam int REG_W    = BCD_W + DATA_W;
    localparam int SAMPLE_W = $clog2(SAMPLE_DIV);
    localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DIG_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    state_e                  state_q, state_d;
    logic [SAMPLE_W-1:0]     sampleCnt_q;
    logic                    sampleTick;
    logic [DATA_W-1:0]       gray_q;
    logic [DATA_W-1:0]       binOut_q;
    logic [DATA_W-1:0]       binNext;
    logic [GRAY_MAX_W-1:0]   binWide;
    logic                    unusedBinHi;
    logic [REG_W-1:0]        bcdShift_q;
    logic [REG_W-1:0]        dabbleAdj;
    logic [REG_W-1:0]        dabbleNext;
    logic [CNT_W-1:0]        shiftCnt_q;
    logic [BCD_W-1:0]        dispReg_q;
    logic [SCAN_W-1:0]       scanCnt_q;
    logic [DIG_W-1:0]        digitIdx_q;
    logic [3:0]              curNibble;
    logic                    curBlank;
    logic [6:0]              segPattern;
    logic [6:0]              segN_q;
    logic [NUM_DIGITS-1:0]   anN_q;

    assign sampleTick = (sampleCnt_q == SAMPLE_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sampleCnt_q <= '0;
        end else if (sampleTick) begin
            sampleCnt_q <= '0;
        end else begin
            sampleCnt_q <= sampleCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Ticks outside IDLE are ignored, so a running conversion is never restarted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sampleTick) state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   if (shiftCnt_q == CNT_W'(DATA_W - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        if (state_q == SHIFT || state_q == DONE) begin
            busy = 1'b1;
        end
    end

    assign binWide     = gray2bin(GRAY_MAX_W'(gray_q));
    assign binNext     = binWide[DATA_W-1:0];
    assign unusedBinHi = ^binWide[GRAY_MAX_W-1:DATA_W];

    // Double-dabble step: correct every BCD nibble of 5 or more, then shift left.
    always_comb begin
        dabbleAdj = bcdShift_q;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (dabbleAdj[DATA_W + 4*d +: 4] >= 4'd5) begin
                dabbleAdj[DATA_W + 4*d +: 4] = dabbleAdj[DATA_W + 4*d +: 4] + 4'd3;
            end
        end
    end

    assign dabbleNext = dabbleAdj << 1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gray_q     <= '0;
            binOut_q   <= '0;
            bcdShift_q <= '0;
            shiftCnt_q <= '0;
            dispReg_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sampleTick) gray_q <= data_in;
                end
                LOAD: begin
                    binOut_q   <= binNext;
                    bcdShift_q <= {{BCD_W{1'b0}}, binNext};
                    shiftCnt_q <= '0;
                end
                SHIFT: begin
                    bcdShift_q <= dabbleNext;
                    shiftCnt_q <= shiftCnt_q + 1'b1;
                end
                DONE: begin
                    dispReg_q <= bcdShift_q[REG_W-1:DATA_W];
                end
                default: ;
            endcase
        end
    end

    // Digit 0 is never blanked so that a value of zero still reads "0".
    always_comb begin
        curNibble = 4'd0;
        curBlank  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digitIdx_q == DIG_W'(i)) begin
                curNibble = dispReg_q[4*i +: 4];
`ifdef LEAD_ZERO_BLANK_EN
                curBlank = (i != 0) && ((dispReg_q >> (4*i)) == '0);
`endif
            end
        end
    end

    seg7_encoder uEncoder (
        .digit_i (curNibble),
        .blank_i (curBlank),
        .seg_n_o (segPattern)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scanCnt_q  <= '0;
            digitIdx_q <= '0;
            segN_q     <= SEG_BLANK;
            anN_q      <= '1;
        end else begin
            segN_q <= segPattern;
            anN_q  <= ~(NUM_DIGITS'(1) << digitIdx_q);
            if (scanCnt_q == SCAN_W'(SCAN_DIV - 1)) begin
                scanCnt_q  <= '0;
                digitIdx_q <= (digitIdx_q == DIG_W'(NUM_DIGITS - 1)) ? '0 : digitIdx_q + 1'b1;
            end else begin
                scanCnt_q <= scanCnt_q + 1'b1;
            end
        end
    end

    assign bin_out = binOut_q;
    assign seg_n   = segN_q;
    assign an_n    = anN_q;

endmodule

// File: tb/tb_gray_bcd_display_ctrl.sv
// Self-checking bench for gray_bcd_display_ctrl: vector table, random Gray values against a
// reference model, and hand-written reset, scan, input-hold and mid-conversion reset sequences.
module tb_gray_bcd_display_ctrl;

    localparam int DATA_W     = 4;
    localparam int NUM_DIGITS = 2;
    localparam int SAMPLE_DIV = 8;
    localparam int SCAN_DIV   = 4;
    localparam int RAND_COUNT = 20;
    localparam int NUM_VECS   = 7;

`ifdef LEAD_ZERO_BLANK_EN
    localparam logic [6:0] D1_ZERO = 7'h7F;
`else
    localparam logic [6:0] D1_ZERO = 7'h40;
`endif

    typedef struct {
        logic [3:0] gray;
        logic [3:0] bin;
        logic [6:0] seg0;
        logic [6:0] seg1;
    } vector_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [DATA_W-1:0]     dataIn = '0;
    logic [DATA_W-1:0]     binOut;
    logic [6:0]            segN;
    logic [NUM_DIGITS-1:0] anN;
    logic                  busy;

    int testsRun  = 0;
    int failCount = 0;
    int sinceRel  = 0;

    vector_t    vectors [NUM_VECS];
    logic [6:0] segTable [10];

    gray_bcd_display_ctrl #(
        .DATA_W     (DATA_W),
        .NUM_DIGITS (NUM_DIGITS),
        .SAMPLE_DIV (SAMPLE_DIV),
        .SCAN_DIV   (SCAN_DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data_in (dataIn),
        .bin_out (binOut),
        .seg_n   (segN),
        .an_n    (anN),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Rising edges seen since reset was last released.
    always @(posedge clk or negedge rst) begin
        if (!rst) sinceRel <= 0;
        else      sinceRel <= sinceRel + 1;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got %0d edges without finishing, required finish before time limit", sinceRel);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h (edge %0d)", name, actual, expected, sinceRel);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] gray);
        dataIn = gray;
    endtask

    task automatic stepTo(input int n);
        while (sinceRel < n) @(negedge clk);
    endtask

    function automatic int nextTick();
        return ((sinceRel / SAMPLE_DIV) + 1) * SAMPLE_DIV;
    endfunction

    function automatic int digitAt(input int n);
        return ((n - 1) / SCAN_DIV) % NUM_DIGITS;
    endfunction

    function automatic int firstEdgeFor(input int from, input int digit);
        int n;
        n = from;
        while (digitAt(n) != digit) n++;
        return n;
    endfunction

    function automatic logic [1:0] expAn(input int digit);
        return (digit == 0) ? 2'b10 : 2'b01;
    endfunction

    // The binary value is the one whose Gray encoding v ^ (v >> 1) matches.
    function automatic int modelBin(input logic [3:0] g);
        for (int v = 0; v < 16; v++) begin
            if ((v ^ (v >> 1)) == int'(g)) return v;
        end
        return -1;
    endfunction

    function automatic logic [6:0] modelSeg(input int value, input int digit);
        int d;
        d = (digit == 0) ? (value % 10) : ((value / 10) % 10);
`ifdef LEAD_ZERO_BLANK_EN
        if (digit != 0 && value < 10) return 7'h7F;
`endif
        return segTable[d];
    endfunction

    task automatic checkDigit(input int n, input int digit, input logic [6:0] expSeg, input string tag);
        stepTo(n);
        checkOutput({tag, " an_n"}, 32'(anN), 32'(expAn(digit)));
        checkOutput({tag, " seg_n"}, 32'(segN), 32'(expSeg));
    endtask

    task automatic convertAndCheck(input logic [3:0] gray, input logic [3:0] expBin,
                                   input logic [6:0] expSeg0, input logic [6:0] expSeg1,
                                   input string tag);
        int e0, n0, n1;
        e0 = nextTick();
        applyStimulus(gray);
        stepTo(e0);
        checkOutput({tag, " busy before load"}, 32'(busy), 32'd0);
        stepTo(e0 + 1);
        checkOutput({tag, " bin_out"}, 32'(binOut), 32'(expBin));
        checkOutput({tag, " busy at load"}, 32'(busy), 32'd1);
        stepTo(e0 + 5);
        checkOutput({tag, " busy in shift"}, 32'(busy), 32'd1);
        stepTo(e0 + 6);
        checkOutput({tag, " busy after done"}, 32'(busy), 32'd0);
        n0 = firstEdgeFor(e0 + 7, 0);
        n1 = firstEdgeFor(e0 + 7, 1);
        if (n0 < n1) begin
            checkDigit(n0, 0, expSeg0, {tag, " digit0"});
            checkDigit(n1, 1, expSeg1, {tag, " digit1"});
        end else begin
            checkDigit(n1, 1, expSeg1, {tag, " digit1"});
            checkDigit(n0, 0, expSeg0, {tag, " digit0"});
        end
    endtask

    initial begin
        int e0, n, v;
        logic [3:0] g;

        segTable = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        vectors[0] = '{gray: 4'b1101, bin: 4'h9, seg0: 7'h10, seg1: D1_ZERO};
        vectors[1] = '{gray: 4'b1000, bin: 4'hF, seg0: 7'h12, seg1: 7'h79};
        vectors[2] = '{gray: 4'b0000, bin: 4'h0, seg0: 7'h40, seg1: D1_ZERO};
        vectors[3] = '{gray: 4'b0001, bin: 4'h1, seg0: 7'h79, seg1: D1_ZERO};
        vectors[4] = '{gray: 4'b1100, bin: 4'h8, seg0: 7'h00, seg1: D1_ZERO};
        vectors[5] = '{gray: 4'b1011, bin: 4'hD, seg0: 7'h30, seg1: 7'h79};
        vectors[6] = '{gray: 4'b0111, bin: 4'h5, seg0: 7'h12, seg1: D1_ZERO};

        // Held in reset with the clock running.
        repeat (3) @(negedge clk);
        checkOutput("reset seg_n", 32'(segN), 32'h7F);
        checkOutput("reset an_n", 32'(anN), 32'h3);
        checkOutput("reset bin_out", 32'(binOut), 32'h0);
        checkOutput("reset busy", 32'(busy), 32'h0);

        // Scan order and dwell from release; the display still holds zero.
        rst = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            stepTo(k);
            checkOutput($sformatf("scan an_n edge %0d", k), 32'(anN), 32'(expAn(digitAt(k))));
            checkOutput($sformatf("scan seg_n edge %0d", k), 32'(segN), 32'(modelSeg(0, digitAt(k))));
        end

        for (int i = 0; i < NUM_VECS; i++) begin
            convertAndCheck(vectors[i].gray, vectors[i].bin, vectors[i].seg0, vectors[i].seg1,
                            $sformatf("vec%0d", i));
        end

        // Input changes two cycles after a tick are invisible until the following tick.
        e0 = nextTick();
        applyStimulus(4'b1101);
        stepTo(e0 + 2);
        applyStimulus(4'b0000);
        stepTo(e0 + 8);
        checkOutput("hold bin_out kept", 32'(binOut), 32'h9);
        stepTo(e0 + 9);
        checkOutput("hold bin_out next", 32'(binOut), 32'h0);
        n = firstEdgeFor(e0 + 9, 0);
        checkDigit(n, 0, 7'h10, "hold old digit0");
        n = firstEdgeFor(e0 + 15, 0);
        checkDigit(n, 0, 7'h40, "hold new digit0");
        n = firstEdgeFor(n, 1);
        checkDigit(n, 1, D1_ZERO, "hold new digit1");

        // Reset asserted between clock edges during SHIFT must act at once.
        e0 = nextTick();
        applyStimulus(4'b1000);
        stepTo(e0 + 1);
        checkOutput("midreset bin_out before", 32'(binOut), 32'hF);
        stepTo(e0 + 3);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midreset seg_n", 32'(segN), 32'h7F);
        checkOutput("midreset an_n", 32'(anN), 32'h3);
        checkOutput("midreset bin_out", 32'(binOut), 32'h0);
        checkOutput("midreset busy", 32'(busy), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        stepTo(1);
        checkOutput("post-reset an_n", 32'(anN), 32'h2);
        checkOutput("post-reset seg_n", 32'(segN), 32'h40);
        checkOutput("post-reset bin_out", 32'(binOut), 32'h0);
        convertAndCheck(4'b1000, 4'hF, 7'h12, 7'h79, "post-reset");

        for (int r = 0; r < RAND_COUNT; r++) begin
            g = 4'($urandom_range(0, 15));
            v = modelBin(g);
            convertAndCheck(g, 4'(v), modelSeg(v, 0), modelSeg(v, 1), $sformatf("rand%0d g=%0h", r, g));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
